// File: rtl/iq_sample_capture_buffer_if.sv
// Capture/read bundle for the I/Q sample capture buffer.
// The master side is the front end plus read clients; the slave side is the buffer.
interface iq_sample_capture_buffer_if #(
    parameter int DW   = 12,
    parameter int AW   = 15,
    parameter int N_RD = 5
);
    logic                 in_valid;
    logic [DW-1:0]        in_i;
    logic [DW-1:0]        in_q;
    logic                 cap_start;
    logic                 cap_busy;
    logic                 cap_done;
    logic                 frozen;
    logic [AW:0]          fill_cnt;
    logic [N_RD-1:0]      rd_en;
    logic [N_RD*AW-1:0]   rd_addr;
    logic [N_RD*DW-1:0]   rd_i;
    logic [N_RD*DW-1:0]   rd_q;
    logic [N_RD-1:0]      rd_valid;
    logic [N_RD-1:0]      rd_err;

    modport master (
        output in_valid, in_i, in_q, cap_start, rd_en, rd_addr,
        input  cap_busy, cap_done, frozen, fill_cnt, rd_i, rd_q, rd_valid, rd_err
    );

    modport slave (
        input  in_valid, in_i, in_q, cap_start, rd_en, rd_addr,
        output cap_busy, cap_done, frozen, fill_cnt, rd_i, rd_q, rd_valid, rd_err
    );
endinterface

// File: rtl/iq_sample_capture_buffer.sv
// Captures DEPTH I/Q samples, freezes them, and serves N_RD independent read channels.
// Read latency RD_LAT (1 or 2); no backpressure, every channel may read every cycle.
module iq_sample_capture_buffer #(
    parameter int DW     = 12,
    parameter int AW     = 15,
    parameter int DEPTH  = 32768,
    parameter int N_RD   = 5,
    parameter int RD_LAT = 1
) (
    input logic                      clk,
    input logic                      rst_n,
    iq_sample_capture_buffer_if.slave bus
);
    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_FROZEN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AW:0]     fill_cnt_q, fill_cnt_d;
    logic            cap_done_q, cap_done_d;
    logic            wr_en;

    logic [2*DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fill_cnt_q <= '0;
            cap_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            cap_done_q <= cap_done_d;
        end
    end

    // A start request in the same cycle as a sample only re-arms; that sample is dropped.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        cap_done_d = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            ST_IDLE, ST_FROZEN: begin
                if (bus.cap_start) begin
                    state_d    = ST_FILL;
                    fill_cnt_d = '0;
                end
            end
            ST_FILL: begin
                if (bus.in_valid) begin
                    wr_en      = 1'b1;
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_q == DEPTH_W - 1'b1) begin
                        state_d    = ST_FROZEN;
                        cap_done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[fill_cnt_q[IW-1:0]] <= {bus.in_i, bus.in_q};
        end
    end

    assign bus.cap_busy = (state_q == ST_FILL);
    assign bus.frozen   = (state_q == ST_FROZEN);
    assign bus.cap_done = cap_done_q;
    assign bus.fill_cnt = fill_cnt_q;

    // Range check happens at request time; the slot being written this cycle is still past fill_cnt.
    logic [AW-1:0]   req_addr [N_RD];
    logic [N_RD-1:0] req_err;
    logic [2*DW-1:0] req_word [N_RD];

    always_comb begin
        for (int k = 0; k < N_RD; k++) begin
            req_addr[k] = bus.rd_addr[k*AW +: AW];
            req_err[k]  = ({1'b0, req_addr[k]} >= DEPTH_W) ||
                          ((state_q != ST_FROZEN) && ({1'b0, req_addr[k]} >= fill_cnt_q));
            req_word[k] = req_err[k] ? '0 : mem[req_addr[k][IW-1:0]];
        end
    end

    logic [N_RD-1:0]    s1_vld_q, s1_err_q;
    logic [N_RD*DW-1:0] s1_i_q, s1_q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= '0;
            s1_err_q <= '0;
            s1_i_q   <= '0;
            s1_q_q   <= '0;
        end else begin
            s1_vld_q <= bus.rd_en;
            s1_err_q <= bus.rd_en & req_err;
            for (int k = 0; k < N_RD; k++) begin
                if (bus.rd_en[k]) begin
                    s1_i_q[k*DW +: DW] <= req_word[k][2*DW-1:DW];
                    s1_q_q[k*DW +: DW] <= req_word[k][DW-1:0];
                end
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [N_RD-1:0]    s2_vld_q, s2_err_q;
            logic [N_RD*DW-1:0] s2_i_q, s2_q_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_vld_q <= '0;
                    s2_err_q <= '0;
                    s2_i_q   <= '0;
                    s2_q_q   <= '0;
                end else begin
                    s2_vld_q <= s1_vld_q;
                    s2_err_q <= s1_err_q;
                    for (int k = 0; k < N_RD; k++) begin
                        if (s1_vld_q[k]) begin
                            s2_i_q[k*DW +: DW] <= s1_i_q[k*DW +: DW];
                            s2_q_q[k*DW +: DW] <= s1_q_q[k*DW +: DW];
                        end
                    end
                end
            end

            assign bus.rd_valid = s2_vld_q;
            assign bus.rd_err   = s2_err_q;
            assign bus.rd_i     = s2_i_q;
            assign bus.rd_q     = s2_q_q;
        end else begin : g_lat1
            assign bus.rd_valid = s1_vld_q;
            assign bus.rd_err   = s1_err_q;
            assign bus.rd_i     = s1_i_q;
            assign bus.rd_q     = s1_q_q;
        end
    endgenerate
endmodule

// File: tb/tb_iq_sample_capture_buffer.sv
// Directed bench: DUT A (DEPTH 32768, RD_LAT 1) and DUT B (DEPTH 1000, RD_LAT 2) share one stimulus.
module tb_iq_sample_capture_buffer;
    localparam int DW = 12;
    localparam int AW = 15;
    localparam int NR = 5;
    localparam int NV = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               in_valid, cap_start;
    logic [DW-1:0]      in_i, in_q;
    logic [NR-1:0]      rd_en;
    logic [NR*AW-1:0]   rd_addr;

    iq_sample_capture_buffer_if #(.DW(DW), .AW(AW), .N_RD(NR)) ifa ();
    iq_sample_capture_buffer_if #(.DW(DW), .AW(AW), .N_RD(NR)) ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_i      = in_i;
    assign ifa.in_q      = in_q;
    assign ifa.cap_start = cap_start;
    assign ifa.rd_en     = rd_en;
    assign ifa.rd_addr   = rd_addr;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_i      = in_i;
    assign ifb.in_q      = in_q;
    assign ifb.cap_start = cap_start;
    assign ifb.rd_en     = rd_en;
    assign ifb.rd_addr   = rd_addr;

    iq_sample_capture_buffer #(.DW(DW), .AW(AW), .DEPTH(32768), .N_RD(NR), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
    );
    iq_sample_capture_buffer #(.DW(DW), .AW(AW), .DEPTH(1000), .N_RD(NR), .RD_LAT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [11:0]   ei;
        logic [11:0]   eq;
        logic          errb;
    } vec_t;

    vec_t tbl [NV];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rd(input bit b, input int k, input logic vld, input logic err,
                          input logic [11:0] ei, input logic [11:0] eq);
        logic v, e;
        logic [11:0] i, q;
        string p;
        if (!b) begin
            v = ifa.rd_valid[k]; e = ifa.rd_err[k];
            i = ifa.rd_i[k*DW +: DW]; q = ifa.rd_q[k*DW +: DW];
        end else begin
            v = ifb.rd_valid[k]; e = ifb.rd_err[k];
            i = ifb.rd_i[k*DW +: DW]; q = ifb.rd_q[k*DW +: DW];
        end
        p = $sformatf("%s ch%0d", b ? "B" : "A", k);
        chk({p, " rd_valid"}, 32'(v), 32'(vld));
        chk({p, " rd_err"},   32'(e), 32'(err));
        chk({p, " rd_i"},     32'(i), 32'(ei));
        chk({p, " rd_q"},     32'(q), 32'(eq));
    endtask

    initial begin
        // Stored pattern: I = n[11:0], Q = ~n[11:0]; errb = out of range for DEPTH 1000.
        tbl[0] = '{15'd0,     12'h000, 12'hFFF, 1'b0};
        tbl[1] = '{15'd1,     12'h001, 12'hFFE, 1'b0};
        tbl[2] = '{15'd100,   12'h064, 12'hF9B, 1'b0};
        tbl[3] = '{15'd32767, 12'hFFF, 12'h000, 1'b1};
        tbl[4] = '{15'd5,     12'h005, 12'hFFA, 1'b0};
        tbl[5] = '{15'd999,   12'h3E7, 12'hC18, 1'b0};
        tbl[6] = '{15'd1000,  12'h3E8, 12'hC17, 1'b1};
        tbl[7] = '{15'd4096,  12'h000, 12'hFFF, 1'b1};
        tbl[8] = '{15'd2049,  12'h801, 12'h7FE, 1'b1};

        in_valid = 1'b0; cap_start = 1'b0; in_i = '0; in_q = '0;
        rd_en = '0; rd_addr = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("A cap_busy rst", 32'(ifa.cap_busy), 0);
        chk("A frozen rst",   32'(ifa.frozen), 0);
        chk("A cap_done rst", 32'(ifa.cap_done), 0);
        chk("A fill_cnt rst", 32'(ifa.fill_cnt), 0);
        chk("A rd_valid rst", 32'(ifa.rd_valid), 0);
        chk("A rd_i rst",     32'(|ifa.rd_i), 0);
        chk("B rd_valid rst", 32'(ifb.rd_valid), 0);
        rst_n = 1'b1;
        step();

        // Reads in IDLE are out of range
        rd_en = 5'b00001; rd_addr = '0;
        step();
        chk_rd(0, 0, 1'b1, 1'b1, 12'h000, 12'h000);
        rd_en = '0;
        step();
        chk_rd(1, 0, 1'b1, 1'b1, 12'h000, 12'h000);

        cap_start = 1'b1;
        step();
        cap_start = 1'b0;
        chk("A cap_busy start", 32'(ifa.cap_busy), 1);
        chk("A fill_cnt start", 32'(ifa.fill_cnt), 0);
        chk("B cap_busy start", 32'(ifb.cap_busy), 1);

        for (int n = 0; n < 32768; n++) begin
            if (n == 10) begin
                rd_en = 5'b00011;
                rd_addr = '0;
                rd_addr[0*AW +: AW] = 15'd9;
                rd_addr[1*AW +: AW] = 15'd10;
            end
            if (n == 11) begin
                chk_rd(0, 0, 1'b1, 1'b0, 12'h009, 12'hFF6);
                chk_rd(0, 1, 1'b1, 1'b1, 12'h000, 12'h000);
                rd_en = '0;
            end
            if (n == 12) begin
                chk_rd(1, 0, 1'b1, 1'b0, 12'h009, 12'hFF6);
                chk_rd(1, 1, 1'b1, 1'b1, 12'h000, 12'h000);
            end
            if (n == 20) begin
                chk("A fill_cnt 20", 32'(ifa.fill_cnt), 20);
                cap_start = 1'b1;
            end
            if (n == 21) begin
                cap_start = 1'b0;
                chk("A fill_cnt after restart", 32'(ifa.fill_cnt), 21);
                chk("A cap_busy after restart", 32'(ifa.cap_busy), 1);
                chk("B fill_cnt after restart", 32'(ifb.fill_cnt), 21);
            end
            if (n == 1000) begin
                chk("B cap_done", 32'(ifb.cap_done), 1);
                chk("B frozen",   32'(ifb.frozen), 1);
                chk("B cap_busy", 32'(ifb.cap_busy), 0);
                chk("B fill_cnt", 32'(ifb.fill_cnt), 1000);
            end
            if (n == 1001) begin
                chk("B cap_done pulse", 32'(ifb.cap_done), 0);
                chk("B fill_cnt hold",  32'(ifb.fill_cnt), 1000);
            end
            if (n == 32767) begin
                chk("A cap_done early", 32'(ifa.cap_done), 0);
                chk("A frozen early",   32'(ifa.frozen), 0);
            end
            in_valid = 1'b1;
            in_i = 12'(n);
            in_q = ~12'(n);
            step();
        end
        in_valid = 1'b0;
        chk("A cap_done", 32'(ifa.cap_done), 1);
        chk("A frozen",   32'(ifa.frozen), 1);
        chk("A cap_busy", 32'(ifa.cap_busy), 0);
        chk("A fill_cnt", 32'(ifa.fill_cnt), 32768);
        step();
        chk("A cap_done pulse", 32'(ifa.cap_done), 0);
        chk("A frozen hold",    32'(ifa.frozen), 1);

        // Frozen: all channels every cycle, rotating through the table
        for (int c = 0; c < NV + 2; c++) begin
            if (c >= 1 && c - 1 < NV) begin
                for (int k = 0; k < NR; k++) begin
                    chk_rd(0, k, 1'b1, 1'b0, tbl[(c-1+k)%NV].ei, tbl[(c-1+k)%NV].eq);
                end
            end
            if (c >= 2 && c - 2 < NV) begin
                for (int k = 0; k < NR; k++) begin
                    if (tbl[(c-2+k)%NV].errb)
                        chk_rd(1, k, 1'b1, 1'b1, 12'h000, 12'h000);
                    else
                        chk_rd(1, k, 1'b1, 1'b0, tbl[(c-2+k)%NV].ei, tbl[(c-2+k)%NV].eq);
                end
            end
            if (c < NV) begin
                rd_en = '1;
                for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = tbl[(c+k)%NV].addr;
            end else begin
                rd_en = '0;
            end
            step();
        end
        // Idle channels hold their last data with rd_err low
        chk_rd(0, 0, 1'b0, 1'b0, tbl[NV-1].ei, tbl[NV-1].eq);
        chk_rd(1, 1, 1'b0, 1'b0, tbl[0].ei, tbl[0].eq);

        // Restart from FROZEN with a sample in the same cycle: sample dropped
        cap_start = 1'b1; in_valid = 1'b1; in_i = 12'hABC; in_q = 12'h543;
        step();
        cap_start = 1'b0; in_valid = 1'b0;
        chk("A restart busy",     32'(ifa.cap_busy), 1);
        chk("A restart fill_cnt", 32'(ifa.fill_cnt), 0);
        chk("B restart fill_cnt", 32'(ifb.fill_cnt), 0);
        in_valid = 1'b1; in_i = 12'h123; in_q = 12'h456;
        step();
        in_valid = 1'b0;
        chk("A fill_cnt first", 32'(ifa.fill_cnt), 1);
        rd_en = 5'b00011; rd_addr = '0;
        rd_addr[1*AW +: AW] = 15'd1;
        step();
        rd_en = '0;
        chk_rd(0, 0, 1'b1, 1'b0, 12'h123, 12'h456);
        chk_rd(0, 1, 1'b1, 1'b1, 12'h000, 12'h000);
        step();
        chk_rd(1, 0, 1'b1, 1'b0, 12'h123, 12'h456);

        // Reset mid-FILL with reads in flight
        in_valid = 1'b1; in_i = 12'h200; in_q = 12'h300;
        rd_en = '1; rd_addr = '0;
        step();
        chk("A rd_valid before rst", 32'(ifa.rd_valid), 32'h1F);
        #1;
        rst_n = 1'b0;
        #1;
        in_valid = 1'b0; rd_en = '0;
        chk("A rd_valid async rst", 32'(ifa.rd_valid), 0);
        chk("A rd_i async rst",     32'(|ifa.rd_i), 0);
        chk("A rd_q async rst",     32'(|ifa.rd_q), 0);
        chk("A fill_cnt async rst", 32'(ifa.fill_cnt), 0);
        chk("A cap_busy async rst", 32'(ifa.cap_busy), 0);
        chk("B rd_valid async rst", 32'(ifb.rd_valid), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("B rd_valid dropped", 32'(ifb.rd_valid), 0);
        chk("A idle after rst",   32'(ifa.cap_busy | ifa.frozen), 0);
        cap_start = 1'b1;
        step();
        cap_start = 1'b0;
        in_valid = 1'b1; in_i = 12'h7AA; in_q = 12'h855;
        step();
        in_valid = 1'b0;
        rd_en = 5'b00001; rd_addr = '0;
        step();
        rd_en = '0;
        chk_rd(0, 0, 1'b1, 1'b0, 12'h7AA, 12'h855);
        chk("A fill_cnt new", 32'(ifa.fill_cnt), 1);
        step();
        chk_rd(1, 0, 1'b1, 1'b0, 12'h7AA, 12'h855);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
